// File: rtl/kbd_led_sched.sv
// Lock-key tracker and "Set LEDs" (0xED + LED byte) command sequencer for the PS/2 host path.
// Owns the transmitter request line; checks ACK/resend, times out waits and retries each byte.
module kbd_led_sched #(
   parameter int TIMEOUT_CYC = 1_000_000,
   parameter int MAX_RETRY   = 3
) (
   input  logic       clk,
   input  logic       resetN,
   input  logic [8:0] keyCode,
   input  logic       make,
   input  logic       brakk,
   input  logic       din_new,
   input  logic [7:0] din,
   input  logic       tx_busy,
   input  logic       tx_done,
   output logic       tx_req,
   output logic [7:0] tx_data,
   output logic [2:0] leds,
   output logic       cmd_busy,
   output logic       cmd_err
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam int RW = $clog2(MAX_RETRY + 2);

   typedef enum logic [2:0] {
      S_IDLE, S_SEND_ED, S_WAIT_TX_ED, S_WAIT_ACK_ED,
      S_SEND_LED, S_WAIT_TX_LED, S_WAIT_ACK_LED
   } state_t;

   state_t          r_state, w_next, w_retry_state;
   logic [2:0]      r_leds, r_held, w_lock_sel, w_toggle;
   logic            r_pending, r_tx_req, r_err;
   logic [7:0]      r_tx_data, r_snap, w_send_byte;
   logic [TW-1:0]   r_timer;
   logic [RW-1:0]   r_retry;
   logic            w_take, w_send, w_retry_req, w_abort, w_ack_ed, w_ack_led;
   logic            w_timeout, w_in_wait;

   // Lock keys map onto the {caps, num, scroll} LED bit order.
   assign w_lock_sel = {keyCode == 9'h058, keyCode == 9'h077, keyCode == 9'h07E};
   assign w_toggle   = make ? (w_lock_sel & ~r_held) : 3'b000;
   assign w_timeout  = (r_timer == TW'(TIMEOUT_CYC - 1));
   assign w_in_wait  = (r_state == S_WAIT_TX_ED)  || (r_state == S_WAIT_ACK_ED) ||
                       (r_state == S_WAIT_TX_LED) || (r_state == S_WAIT_ACK_LED);

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next        = r_state;
      w_retry_state = S_SEND_ED;
      w_take        = 1'b0;
      w_send        = 1'b0;
      w_send_byte   = 8'h00;
      w_retry_req   = 1'b0;
      w_ack_ed      = 1'b0;
      w_ack_led     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (r_pending) begin
               w_take = 1'b1;
               w_next = S_SEND_ED;
            end
         end
         S_SEND_ED: begin
            if (!tx_busy) begin
               w_send      = 1'b1;
               w_send_byte = 8'hED;
               w_next      = S_WAIT_TX_ED;
            end
         end
         S_WAIT_TX_ED: begin
            if (tx_done)        w_next      = S_WAIT_ACK_ED;
            else if (w_timeout) w_retry_req = 1'b1;
         end
         S_WAIT_ACK_ED: begin
            if (din_new && din == 8'hFA) begin
               w_ack_ed = 1'b1;
               w_next   = S_SEND_LED;
            end else if ((din_new && din == 8'hFE) || w_timeout) begin
               w_retry_req = 1'b1;
            end
         end
         S_SEND_LED: begin
            if (!tx_busy) begin
               w_send      = 1'b1;
               w_send_byte = r_snap;
               w_next      = S_WAIT_TX_LED;
            end
         end
         S_WAIT_TX_LED: begin
            w_retry_state = S_SEND_LED;
            if (tx_done)        w_next      = S_WAIT_ACK_LED;
            else if (w_timeout) w_retry_req = 1'b1;
         end
         S_WAIT_ACK_LED: begin
            w_retry_state = S_SEND_LED;
            if (din_new && din == 8'hFA) begin
               w_ack_led = 1'b1;
               w_next    = S_IDLE;
            end else if ((din_new && din == 8'hFE) || w_timeout) begin
               w_retry_req = 1'b1;
            end
         end
         default: w_next = S_IDLE;
      endcase
      // A retry that would push the count past MAX_RETRY aborts the whole command.
      w_abort = w_retry_req && (r_retry == RW'(MAX_RETRY));
      if (w_retry_req) w_next = w_abort ? S_IDLE : w_retry_state;
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_leds    <= 3'b000;
         r_held    <= 3'b000;
         r_pending <= 1'b0;
         r_snap    <= 8'h00;
         r_tx_req  <= 1'b0;
         r_tx_data <= 8'h00;
         r_err     <= 1'b0;
         r_timer   <= '0;
         r_retry   <= '0;
      end else begin
         r_leds <= r_leds ^ w_toggle;
         r_held <= (r_held | (make ? w_lock_sel : 3'b000)) & ~(brakk ? w_lock_sel : 3'b000);
         // A new toggle wins over IDLE consuming the previous request.
         if (|w_toggle)   r_pending <= 1'b1;
         else if (w_take) r_pending <= 1'b0;
         if (w_take) r_snap <= {5'b00000, r_leds};
         r_tx_req <= w_send;
         if (w_send) r_tx_data <= w_send_byte;
         if (w_abort)        r_err <= 1'b1;
         else if (w_ack_led) r_err <= 1'b0;
         if (w_next != r_state)               r_timer <= '0;
         else if (w_in_wait && !w_timeout)    r_timer <= r_timer + 1'b1;
         if (w_take || w_ack_ed)              r_retry <= '0;
         else if (w_retry_req && !w_abort)    r_retry <= r_retry + 1'b1;
      end
   end

   assign tx_req   = r_tx_req;
   assign tx_data  = r_tx_data;
   assign leds     = r_leds;
   assign cmd_busy = (r_state != S_IDLE);
   assign cmd_err  = r_err;

endmodule
